// File: rtl/seg_rx_decoder_if.sv
// ============================================================================
// seg_rx_decoder_if : seven-segment receive bus (pattern in, decoded state out)
// Rev 1.0
// ============================================================================
`default_nettype none

interface seg_rx_decoder_if #(
    parameter int CNT_W = 16
);
    logic [8:0]       seg_in;
    logic [3:0]       digit;
    logic             dp;
    logic             valid;
    logic             blank;
    logic             upd;
    logic             err;
    logic [CNT_W-1:0] upd_cnt;

    modport master (
        output seg_in,
        input  digit, dp, valid, blank, upd, err, upd_cnt
    );

    modport slave (
        input  seg_in,
        output digit, dp, valid, blank, upd, err, upd_cnt
    );
endinterface

`default_nettype wire

// File: rtl/seg_rx_decoder.sv
// ============================================================================
// seg_rx_decoder : sync + stability filter + settle FSM + segment-to-hex decode
// Optional update counter enabled by SEG_RX_CNT_EN.                   Rev 1.0
// ============================================================================
`default_nettype none

module seg_rx_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    seg_rx_decoder_if.slave bus
);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pre  = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [8:0]       c_idle = 9'h100;

    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2,
        ST_BAD    = 2'd3
    } state_t;

    state_t           r_state;
    logic [8:0]       r_s1, r_s2, r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_digit;
    logic             r_dp, r_valid, r_blank, r_upd, r_err;

    logic [3:0]       w_hex;
    logic             w_hit, w_dark, w_accept, w_upd_set;

    always_comb begin
        w_hit = 1'b1;
        w_hex = 4'h0;
        case (r_cand[6:0])
            7'h3F: w_hex = 4'h0;
            7'h06: w_hex = 4'h1;
            7'h5B: w_hex = 4'h2;
            7'h4F: w_hex = 4'h3;
            7'h66: w_hex = 4'h4;
            7'h6D: w_hex = 4'h5;
            7'h7D: w_hex = 4'h6;
            7'h07: w_hex = 4'h7;
            7'h7F: w_hex = 4'h8;
            7'h6F: w_hex = 4'h9;
            7'h77: w_hex = 4'hA;
            7'h7C: w_hex = 4'hB;
            7'h39: w_hex = 4'hC;
            7'h5E: w_hex = 4'hD;
            7'h79: w_hex = 4'hE;
            7'h71: w_hex = 4'hF;
            default: w_hit = 1'b0;
        endcase
    end

    // DIG is an active-low enable; a disabled digit or no lit segment reads as dark
    assign w_dark    = r_cand[8] | (r_cand[6:0] == 7'h00);
    assign w_accept  = (r_s2 == r_cand) && (r_state == ST_SETTLE) && (r_cnt == c_pre);
    assign w_upd_set = w_accept && (w_dark ? r_valid
                     : (w_hit && (!r_valid || ({r_digit, r_dp} != {w_hex, r_cand[7]}))));

    always_ff @(posedge clk) begin
        r_upd <= 1'b0;
        r_err <= 1'b0;
        if (rst) begin
            r_s1    <= c_idle;
            r_s2    <= c_idle;
            r_cand  <= c_idle;
            r_cnt   <= '0;
            r_state <= ST_BLANK;
            r_digit <= 4'h0;
            r_dp    <= 1'b0;
            r_valid <= 1'b0;
            r_blank <= 1'b1;
        end else begin
            r_s1 <= bus.seg_in;
            r_s2 <= r_s1;
            if (r_s2 != r_cand) begin
                r_cand  <= r_s2;
                r_cnt   <= '0;
                r_state <= ST_SETTLE;
            end else if (r_state == ST_SETTLE) begin
                if (w_accept) begin
                    r_cnt <= c_last;
                    r_upd <= w_upd_set;
                    if (w_dark) begin
                        r_state <= ST_BLANK;
                        r_valid <= 1'b0;
                        r_blank <= 1'b1;
                    end else if (w_hit) begin
                        r_state <= ST_LOCKED;
                        r_digit <= w_hex;
                        r_dp    <= r_cand[7];
                        r_valid <= 1'b1;
                        r_blank <= 1'b0;
                    end else begin
                        r_state <= ST_BAD;
                        r_valid <= 1'b0;
                        r_blank <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= c_last;
            end
        end
    end

`ifdef SEG_RX_CNT_EN
    logic [CNT_W-1:0] r_upd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_cnt <= '0;
        end else if (w_upd_set) begin
            r_upd_cnt <= r_upd_cnt + 1'b1;
        end
    end

    assign bus.upd_cnt = r_upd_cnt;
`else
    assign bus.upd_cnt = '0;
`endif

    assign bus.digit = r_digit;
    assign bus.dp    = r_dp;
    assign bus.valid = r_valid;
    assign bus.blank = r_blank;
    assign bus.upd   = r_upd;
    assign bus.err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_seg_rx_decoder.sv
// ============================================================================
// tb_seg_rx_decoder : directed self-checking bench for seg_rx_decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seg_rx_decoder;
`ifdef SEG_RX_CNT_EN
    localparam bit c_cnt_en = 1'b1;
`else
    localparam bit c_cnt_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;
    logic seen_upd, seen_err;

    seg_rx_decoder_if #(.CNT_W(16)) bus ();

    seg_rx_decoder #(
        .STABLE_CYCLES(4),
        .CNT_W        (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        check_val(tag, 32'(bus.upd_cnt), c_cnt_en ? 32'(exp_cnt) : 32'd0);
    endtask

    initial begin
        bus.seg_in = 9'h000;
        rst        = 1'b1;
        step(2);
        check_val("rst_valid", 32'(bus.valid), 0);
        check_val("rst_blank", 32'(bus.blank), 1);
        check_val("rst_upd",   32'(bus.upd),   0);
        check_val("rst_err",   32'(bus.err),   0);
        check_val("rst_digit", 32'(bus.digit), 0);
        check_cnt("rst_cnt");
        rst = 1'b0;
        step(8);
        check_val("idle_blank", 32'(bus.blank), 1);
        check_cnt("idle_cnt");

        // digit 3: accepted on the 6th edge after it is applied
        bus.seg_in = 9'h04F;
        step(5);
        check_val("d3_e5_valid", 32'(bus.valid), 0);
        check_val("d3_e5_upd",   32'(bus.upd),   0);
        step(1);
        exp_cnt++;
        check_val("d3_digit", 32'(bus.digit), 3);
        check_val("d3_valid", 32'(bus.valid), 1);
        check_val("d3_blank", 32'(bus.blank), 0);
        check_val("d3_upd",   32'(bus.upd),   1);
        check_cnt("d3_cnt");
        step(1);
        check_val("d3_upd_off", 32'(bus.upd), 0);

        // DIG disabled with segments lit: dark, leaving LOCKED pulses upd
        bus.seg_in = 9'h17F;
        step(6);
        exp_cnt++;
        check_val("dk_blank", 32'(bus.blank), 1);
        check_val("dk_valid", 32'(bus.valid), 0);
        check_val("dk_upd",   32'(bus.upd),   1);
        check_val("dk_digit", 32'(bus.digit), 3);
        check_cnt("dk_cnt");
        step(1);
        bus.seg_in = 9'h0FF;
        step(6);
        exp_cnt++;
        check_val("d8_digit", 32'(bus.digit), 8);
        check_val("d8_dp",    32'(bus.dp),    1);
        check_val("d8_valid", 32'(bus.valid), 1);
        check_val("d8_upd",   32'(bus.upd),   1);
        check_cnt("d8_cnt");

        // digit 1, then a 2-cycle glitch to 8 that must be filtered
        bus.seg_in = 9'h006;
        step(6);
        exp_cnt++;
        check_val("d1_digit", 32'(bus.digit), 1);
        check_val("d1_dp",    32'(bus.dp),    0);
        check_val("d1_upd",   32'(bus.upd),   1);
        step(2);
        seen_upd = 1'b0;
        seen_err = 1'b0;
        bus.seg_in = 9'h07F;
        for (int i = 0; i < 2; i++) begin
            step(1);
            seen_upd |= bus.upd;
            seen_err |= bus.err;
        end
        bus.seg_in = 9'h006;
        for (int i = 0; i < 12; i++) begin
            step(1);
            seen_upd |= bus.upd;
            seen_err |= bus.err;
        end
        check_val("gl_upd",   32'(seen_upd),  0);
        check_val("gl_err",   32'(seen_err),  0);
        check_val("gl_digit", 32'(bus.digit), 1);
        check_val("gl_valid", 32'(bus.valid), 1);
        check_cnt("gl_cnt");

        // letter A
        bus.seg_in = 9'h077;
        step(6);
        exp_cnt++;
        check_val("dA_digit", 32'(bus.digit), 4'hA);
        check_val("dA_upd",   32'(bus.upd),   1);
        step(1);

        // 0x49 is not in the table
        bus.seg_in = 9'h049;
        step(5);
        check_val("bad_e5_err", 32'(bus.err), 0);
        step(1);
        check_val("bad_err",   32'(bus.err),   1);
        check_val("bad_valid", 32'(bus.valid), 0);
        check_val("bad_blank", 32'(bus.blank), 0);
        check_val("bad_upd",   32'(bus.upd),   0);
        check_val("bad_digit", 32'(bus.digit), 4'hA);
        check_cnt("bad_cnt");
        step(1);
        check_val("bad_err_off", 32'(bus.err), 0);

        // reset on the 3rd edge of a settle of digit 4
        bus.seg_in = 9'h066;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_cnt = 0;
        check_val("mr_valid", 32'(bus.valid), 0);
        check_val("mr_blank", 32'(bus.blank), 1);
        check_val("mr_upd",   32'(bus.upd),   0);
        check_cnt("mr_cnt");
        step(5);
        check_val("mr_e5_upd", 32'(bus.upd), 0);
        step(1);
        exp_cnt++;
        check_val("d4_digit", 32'(bus.digit), 4);
        check_val("d4_valid", 32'(bus.valid), 1);
        check_val("d4_upd",   32'(bus.upd),   1);
        check_cnt("d4_cnt");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
